// File: rtl/dm_lsu.sv
// Data memory with load/store front end: byte/half/word stores with lane enables,
// sign/zero-extending loads returned one cycle later, and address-window fault tracking.
module dm_lsu #(
    parameter logic [31:0] BASE_ADDR   = 32'h66000000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    input  logic        clr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rd_o,
    output logic        err_o,
    output logic        fault_o,
    output logic [31:0] fault_addr_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS) << 2;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             in_range;
    logic             misaligned;
    logic             fault;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rword;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [31:0]      ldata;

    // The lower-bound test guards the subtraction, so offset never wraps when in range.
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        in_range = (addr_i >= BASE_ADDR) && (offset < WIN_BYTES);
        idx      = offset[IDX_W+1:2];
        lane     = addr_i[1:0];
        accept   = req_i & ready_o;

        misaligned = 1'b0;
        be         = 4'b0000;
        wdata      = wd_i;
        case (size_i)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{wd_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{wd_i[15:0]}};
            end
            2'b10: begin
                misaligned = |addr_i[1:0];
                be         = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase

        fault = accept & (~in_range | misaligned);
    end

    always_comb begin
        rword = mem[idx];
        case (lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = lane[1] ? rword[31:16] : rword[15:0];

        case (size_i)
            2'b00:   ldata = {{24{~unsigned_i & rbyte[7]}}, rbyte};
            2'b01:   ldata = {{16{~unsigned_i & rhalf[15]}}, rhalf};
            default: ldata = rword;
        endcase
    end

    // Memory array is deliberately not reset; reset only suppresses a pending write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept && we_i && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_o  <= 1'b0;
            rvalid_o <= 1'b0;
            rd_o     <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            ready_o  <= 1'b1;
            rvalid_o <= accept & ~we_i;
            err_o    <= fault;
            if (accept && !we_i) begin
                rd_o <= fault ? 32'd0 : ldata;
            end
        end
    end

    // A new fault outranks a same-cycle clear; otherwise only the first fault is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_o      <= 1'b0;
            fault_addr_o <= 32'd0;
        end else if (fault && (!fault_o || clr_i)) begin
            fault_o      <= 1'b1;
            fault_addr_o <= addr_i;
        end else if (clr_i) begin
            fault_o      <= 1'b0;
            fault_addr_o <= 32'd0;
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: a byte-level memory model predicts every cycle's
// outputs, which are queued when stimulus is driven and compared one cycle later.
module tb_dm_lsu;

    localparam logic [31:0] BASE   = 32'h66000000;
    localparam int          DEPTH  = 64;
    localparam int          NBYTES = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        clr;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rd_o;
    logic        err_o;
    logic        fault_o;
    logic [31:0] fault_addr_o;

    dm_lsu #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .size_i      (size),
        .unsigned_i  (uns),
        .addr_i      (addr),
        .wd_i        (wd),
        .clr_i       (clr),
        .ready_o     (ready_o),
        .rvalid_o    (rvalid_o),
        .rd_o        (rd_o),
        .err_o       (err_o),
        .fault_o     (fault_o),
        .fault_addr_o(fault_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rvalid;
        logic        err;
        logic        ready;
        logic        fault;
        logic [31:0] rd;
        logic [31:0] fault_addr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  mb [NBYTES];
    logic        m_ready = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_fa    = 32'd0;
    logic [31:0] m_rd    = 32'd0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkPending();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.tag, ".rvalid"}, {31'd0, rvalid_o}, {31'd0, e.rvalid});
            checkOutput({e.tag, ".err"}, {31'd0, err_o}, {31'd0, e.err});
            checkOutput({e.tag, ".ready"}, {31'd0, ready_o}, {31'd0, e.ready});
            checkOutput({e.tag, ".rd"}, rd_o, e.rd);
            checkOutput({e.tag, ".fault"}, {31'd0, fault_o}, {31'd0, e.fault});
            checkOutput({e.tag, ".fault_addr"}, fault_addr_o, e.fault_addr);
        end
    endtask

    // Checks the previous cycle's prediction, drives one cycle, predicts its outcome.
    task automatic applyStimulus(input string tag, input logic r, input logic q, input logic w,
                                 input logic [1:0] sz, input logic u, input logic [31:0] a,
                                 input logic [31:0] d, input logic c);
        exp_t        e;
        logic        acc;
        logic        bad;
        int          nb;
        int          off;
        logic [31:0] val;
        @(negedge clk);
        checkPending();
        rst = r; req = q; we = w; size = sz; uns = u; addr = a; wd = d; clr = c;

        e.tag = tag;
        if (r) begin
            m_ready = 1'b0; m_fault = 1'b0; m_fa = 32'd0; m_rd = 32'd0;
            e.rvalid = 1'b0;
            e.err    = 1'b0;
        end else begin
            acc = q && m_ready;
            nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            bad = (a < BASE) || (a > BASE + NBYTES - 1) || (sz == 2'b11) || ((a % nb) != 0);
            e.rvalid = acc && !w;
            e.err    = acc && bad;
            if (acc && !bad) begin
                off = int'(a - BASE);
                if (w) begin
                    for (int i = 0; i < nb; i++) mb[off+i] = d[8*i +: 8];
                end else begin
                    val = 32'd0;
                    for (int i = 0; i < nb; i++) val[8*i +: 8] = mb[off+i];
                    if (!u && val[8*nb-1]) begin
                        for (int i = 8*nb; i < 32; i++) val[i] = 1'b1;
                    end
                    m_rd = val;
                end
            end else if (acc && !w) begin
                m_rd = 32'd0;
            end
            if (acc && bad && (!m_fault || c)) begin
                m_fault = 1'b1;
                m_fa    = a;
            end else if (c) begin
                m_fault = 1'b0;
                m_fa    = 32'd0;
            end
            m_ready = 1'b1;
        end
        e.ready      = m_ready;
        e.rd         = m_rd;
        e.fault      = m_fault;
        e.fault_addr = m_fa;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'd0; wd = 32'd0; clr = 1'b0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'd0;

        $display("[TB] reset and request-during-reset");
        applyStimulus("rst", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'd0, 1'b0);
        applyStimulus("rst_load", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'd0, 1'b0);
        idle("post_rst0");
        checkOutput("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("rst_rd", rd_o, 32'd0);
        idle("post_rst1");
        checkOutput("ready_after_rst", {31'd0, ready_o}, 32'd1);

        $display("[TB] 64 back-to-back stores then loads");
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("sw_fill", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'(4*i), 32'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("lw_fill", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(4*i), 32'd0, 1'b0);

        $display("[TB] directed load/store cases");
        applyStimulus("sw_dead", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'd4, 32'hDEADBEEF, 1'b0);
        applyStimulus("lw_dead", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
        idle("i0");
        checkOutput("lw_deadbeef", rd_o, 32'hDEADBEEF);
        checkOutput("lw_deadbeef_valid", {31'd0, rvalid_o}, 32'd1);
        checkOutput("lw_deadbeef_err", {31'd0, err_o}, 32'd0);

        applyStimulus("sb_80", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, BASE + 32'd6, 32'h00000080, 1'b0);
        applyStimulus("lw_sb", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
        idle("i1");
        checkOutput("lw_after_sb", rd_o, 32'hDE80BEEF);
        applyStimulus("lb", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, BASE + 32'd6, 32'd0, 1'b0);
        idle("i2");
        checkOutput("lb_sext", rd_o, 32'hFFFFFF80);
        applyStimulus("lbu", 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, BASE + 32'd6, 32'd0, 1'b0);
        idle("i3");
        checkOutput("lbu_zext", rd_o, 32'h00000080);

        applyStimulus("sh", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, BASE + 32'd2, 32'hFFFF1234, 1'b0);
        applyStimulus("lhu", 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, BASE + 32'd2, 32'd0, 1'b0);
        idle("i4");
        checkOutput("lhu", rd_o, 32'h00001234);
        applyStimulus("lh_mis", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, BASE + 32'd1, 32'd0, 1'b0);
        idle("i5");
        checkOutput("lh_mis_err", {31'd0, err_o}, 32'd1);
        checkOutput("lh_mis_rd", rd_o, 32'd0);
        checkOutput("lh_mis_fa", fault_addr_o, 32'h66000001);
        applyStimulus("clr0", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);

        $display("[TB] out-of-range faults and sticky register");
        applyStimulus("sw_oor", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h66000100, 32'hCAFEF00D, 1'b0);
        idle("i6");
        checkOutput("sw_oor_err", {31'd0, err_o}, 32'd1);
        checkOutput("sw_oor_rvalid", {31'd0, rvalid_o}, 32'd0);
        applyStimulus("sw_low", 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h65FFFFFC, 32'h12345678, 1'b0);
        idle("i7");
        checkOutput("fa_kept", fault_addr_o, 32'h66000100);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("reread", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(4*i), 32'd0, 1'b0);
        applyStimulus("fault_clr", 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, BASE + 32'd3, 32'd0, 1'b1);
        idle("i8");
        checkOutput("fault_beats_clr", fault_addr_o, 32'h66000003);
        applyStimulus("clr1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
        idle("i9");
        checkOutput("clr_fault", {31'd0, fault_o}, 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand", 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          BASE - 32'd4 + 32'($urandom_range(0, NBYTES + 7)), $urandom,
                          1'($urandom_range(0, 15) == 0));
        end
        idle("drain");
        @(negedge clk);
        checkPending();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
